// File: rtl/ex_pkg.sv
// ex_pkg: shared definitions for the execute stage.
//   - ALU/MDU operation codes (4-bit)
//   - FSM state type for the execute stage controller
//   - divide-by-zero result constants
//   - helper identifying operations that use the iterative engine
package ex_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;
  localparam logic [3:0] OP_DIVU = 4'd9;
  localparam logic [3:0] OP_REMU = 4'd10;

  // Divide by zero: every quotient bit is this value (all ones); the
  // remainder equals the dividend, which the restoring algorithm yields
  // naturally when the divisor is zero.
  localparam logic DIV0_QUO_BIT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ITER,
    ST_HOLD
  } state_t;

  function automatic logic is_iter_op(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/ex_mc_stage_mul_div_iter.sv
// mul_div_iter: iterative multiply / unsigned divide engine.
//   One shift-add (MUL) or restoring-subtract (DIVU/REMU) step per cycle,
//   WIDTH steps per operation.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   clear       synchronous abort of the running operation
//   start       latch operands a/b and op, begin iterating
//   op          operation code (OP_MUL / OP_DIVU / OP_REMU)
//   a, b        operands (multiplicand/multiplier or dividend/divisor)
//   done        high during the cycle whose edge completes the final step
//   result      value after the final step (valid while done is high)
module mul_div_iter
  import ex_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic             running;
  logic [CNT_W-1:0] cnt;
  logic             is_mul;
  logic             rem_sel;
  logic             div0;

  // MUL: acc = partial product, opa = shifted multiplicand, opb = multiplier
  // DIV: acc = partial remainder, opa = dividend shifting into quotient,
  //      opb = divisor
  logic [WIDTH-1:0] acc, opa, opb;
  logic [WIDTH-1:0] acc_nxt, opa_nxt, opb_nxt;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] quo;

  always_comb begin
    acc_nxt = acc;
    opa_nxt = opa;
    opb_nxt = opb;
    trial   = '0;
    if (is_mul) begin
      if (opb[0]) acc_nxt = acc + opa;
      opa_nxt = opa << 1;
      opb_nxt = opb >> 1;
    end else begin
      trial = {acc, opa[WIDTH-1]};
      if (trial >= {1'b0, opb}) begin
        acc_nxt = WIDTH'(trial - {1'b0, opb});
        opa_nxt = {opa[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = trial[WIDTH-1:0];
        opa_nxt = {opa[WIDTH-2:0], 1'b0};
      end
    end
  end

  // The final step is forwarded combinationally so the caller can register
  // the result on the same edge that completes the last iteration.
  assign done = running && (cnt == LAST);
  assign quo  = div0 ? {WIDTH{DIV0_QUO_BIT}} : opa_nxt;
  assign result = (is_mul || rem_sel) ? acc_nxt : quo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
      cnt     <= '0;
      is_mul  <= 1'b0;
      rem_sel <= 1'b0;
      div0    <= 1'b0;
      acc     <= '0;
      opa     <= '0;
      opb     <= '0;
    end else if (clear) begin
      running <= 1'b0;
      cnt     <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      is_mul  <= (op == OP_MUL);
      rem_sel <= (op == OP_REMU);
      div0    <= (b == '0);
      acc     <= '0;
      opa     <= a;
      opb     <= b;
    end else if (running) begin
      acc <= acc_nxt;
      opa <= opa_nxt;
      opb <= opb_nxt;
      if (done) begin
        running <= 1'b0;
        cnt     <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ex_mc_stage.sv
// ex_mc_stage: execute stage with operand forwarding, single-cycle ALU and
// an iterative multiply/divide engine; results are registered behind a
// valid/ready handshake.
// Ports:
//   clk, rst_n, flush           clock, async active-low reset, sync kill
//   in_valid / in_ready         upstream handshake (ID/EX)
//   alu_op, alu_src             operation code, operand-B source select
//   pc_in, rs1_data, rs2_data, imm, rd   instruction operands
//   forward_a, forward_b, fwd_data       forwarding selects and sources
//   out_valid / out_ready       downstream handshake (EX2/MEM)
//   alu_result, branch_target, zero, rd_out   registered results
//   busy                        multi-cycle operation iterating
module ex_mc_stage
  import ex_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned NUM_FWD = 2,
  parameter int unsigned RD_W    = 4,
  parameter int unsigned FSEL_W  = $clog2(NUM_FWD + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               alu_op,
  input  logic                     alu_src,
  input  logic [WIDTH-1:0]         pc_in,
  input  logic [WIDTH-1:0]         rs1_data,
  input  logic [WIDTH-1:0]         rs2_data,
  input  logic [WIDTH-1:0]         imm,
  input  logic [RD_W-1:0]          rd,
  input  logic [FSEL_W-1:0]        forward_a,
  input  logic [FSEL_W-1:0]        forward_b,
  input  logic [NUM_FWD*WIDTH-1:0] fwd_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         alu_result,
  output logic [WIDTH-1:0]         branch_target,
  output logic                     zero,
  output logic [RD_W-1:0]          rd_out,
  output logic                     busy
);

  localparam int unsigned SH_W = $clog2(WIDTH);

  // Forwarding sources and operand muxes
  logic [WIDTH-1:0] fwd_src [NUM_FWD];
  logic [WIDTH-1:0] op_a, fwd_b, op_b;

  for (genvar i = 0; i < NUM_FWD; i++) begin : g_fwd
    assign fwd_src[i] = fwd_data[i*WIDTH +: WIDTH];
  end

  // Select values beyond NUM_FWD fall through to register data.
  always_comb begin
    op_a  = rs1_data;
    fwd_b = rs2_data;
    for (int unsigned k = 1; k <= NUM_FWD; k++) begin
      if (forward_a == FSEL_W'(k)) op_a  = fwd_src[k-1];
      if (forward_b == FSEL_W'(k)) fwd_b = fwd_src[k-1];
    end
    op_b = alu_src ? imm : fwd_b;
  end

  // Single-cycle ALU
  logic [WIDTH-1:0] alu_val;

  always_comb begin
    alu_val = '0;
    case (alu_op)
      OP_ADD:  alu_val = op_a + op_b;
      OP_SUB:  alu_val = op_a - op_b;
      OP_AND:  alu_val = op_a & op_b;
      OP_OR:   alu_val = op_a | op_b;
      OP_XOR:  alu_val = op_a ^ op_b;
      OP_SLL:  alu_val = op_a << op_b[SH_W-1:0];
      OP_SRL:  alu_val = op_a >> op_b[SH_W-1:0];
      OP_SLT:  alu_val = WIDTH'($signed(op_a) < $signed(op_b));
      default: alu_val = '0;
    endcase
  end

  // Controller
  state_t state, state_nxt;
  logic   accept, consume;
  logic   load_single, load_iter, eng_start;
  logic   eng_done;
  logic [WIDTH-1:0] eng_result;
  logic [WIDTH-1:0] pend_bt;
  logic [RD_W-1:0]  pend_rd;

  assign in_ready = rst_n && (state == ST_IDLE) && (!out_valid || out_ready) && !flush;
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid && out_ready;
  assign busy     = (state == ST_ITER);

  always_comb begin
    state_nxt   = state;
    load_single = 1'b0;
    load_iter   = 1'b0;
    eng_start   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (is_iter_op(alu_op)) begin
            eng_start = 1'b1;
            state_nxt = ST_ITER;
          end else begin
            load_single = 1'b1;
            state_nxt   = out_ready ? ST_IDLE : ST_HOLD;
          end
        end
      end
      ST_ITER: begin
        if (eng_done) begin
          load_iter = 1'b1;
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (consume) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (flush) begin
      state_nxt   = ST_IDLE;
      load_single = 1'b0;
      load_iter   = 1'b0;
      eng_start   = 1'b0;
    end
  end

  mul_div_iter #(
    .WIDTH(WIDTH)
  ) u_mdu (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (flush),
    .start  (eng_start),
    .op     (alu_op),
    .a      (op_a),
    .b      (op_b),
    .done   (eng_done),
    .result (eng_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      out_valid     <= 1'b0;
      alu_result    <= '0;
      branch_target <= '0;
      zero          <= 1'b0;
      rd_out        <= '0;
      pend_bt       <= '0;
      pend_rd       <= '0;
    end else begin
      state <= state_nxt;
      if (eng_start) begin
        pend_bt <= pc_in + imm;
        pend_rd <= rd;
      end
      if (flush) begin
        out_valid <= 1'b0;
      end else if (load_single) begin
        out_valid     <= 1'b1;
        alu_result    <= alu_val;
        zero          <= (alu_val == '0);
        branch_target <= pc_in + imm;
        rd_out        <= rd;
      end else if (load_iter) begin
        out_valid     <= 1'b1;
        alu_result    <= eng_result;
        zero          <= (eng_result == '0);
        branch_target <= pend_bt;
        rd_out        <= pend_rd;
      end else if (consume) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ex_mc_stage.sv
module tb_ex_mc_stage;
  import ex_pkg::*;

  localparam int unsigned W   = 16;
  localparam int unsigned NF  = 2;
  localparam int unsigned RDW = 4;
  localparam int unsigned FW  = $clog2(NF + 1);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [3:0]      alu_op = '0;
  logic            alu_src = 1'b0;
  logic [W-1:0]    pc_in = '0, rs1_data = '0, rs2_data = '0, imm = '0;
  logic [RDW-1:0]  rd = '0;
  logic [FW-1:0]   forward_a = '0, forward_b = '0;
  logic [NF*W-1:0] fwd_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [W-1:0]    alu_result, branch_target;
  logic            zero;
  logic [RDW-1:0]  rd_out;
  logic            busy;

  always #5 clk = ~clk;

  ex_mc_stage #(.WIDTH(W), .NUM_FWD(NF), .RD_W(RDW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .alu_src(alu_src), .pc_in(pc_in), .rs1_data(rs1_data),
    .rs2_data(rs2_data), .imm(imm), .rd(rd), .forward_a(forward_a), .forward_b(forward_b),
    .fwd_data(fwd_data), .out_valid(out_valid), .out_ready(out_ready),
    .alu_result(alu_result), .branch_target(branch_target), .zero(zero),
    .rd_out(rd_out), .busy(busy)
  );

  typedef struct {
    logic           iv;
    logic [3:0]     op;
    logic           src;
    logic [W-1:0]   pc, rs1, rs2, imm;
    logic [RDW-1:0] rd;
    logic [FW-1:0]  fa, fb;
    logic [NF*W-1:0] fwd;
    logic           ordy;
    logic           fl;
  } txn_t;

  typedef struct {
    logic [W-1:0]   res, bt;
    logic [RDW-1:0] rd;
    int unsigned    acc, due;
    bit             multi, hold;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference behaviour from the operation definitions
  function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned ua = a;
    int unsigned ub = b;
    int sa = $signed(a);
    int sb = $signed(b);
    case (op)
      4'd0:  return W'(ua + ub);
      4'd1:  return W'(ua - ub);
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return W'(ua << (ub % W));
      4'd6:  return W'(ua >> (ub % W));
      4'd7:  return (sa < sb) ? W'(1) : W'(0);
      4'd8:  return W'(ua * ub);
      4'd9:  return (ub == 0) ? '1 : W'(ua / ub);
      4'd10: return (ub == 0) ? a : W'(ua % ub);
      default: return '0;
    endcase
  endfunction

  function automatic logic [W-1:0] pick(input logic [FW-1:0] fs, input logic [W-1:0] r, input logic [NF*W-1:0] f);
    int k = int'(fs);
    if (k >= 1 && k <= int'(NF)) return f[(k-1)*W +: W];
    return r;
  endfunction

  task automatic drive(input txn_t t, output bit accepted);
    exp_t e;
    logic [W-1:0] a, b;
    @(negedge clk);
    in_valid = t.iv; alu_op = t.op; alu_src = t.src; pc_in = t.pc;
    rs1_data = t.rs1; rs2_data = t.rs2; imm = t.imm; rd = t.rd;
    forward_a = t.fa; forward_b = t.fb; fwd_data = t.fwd;
    out_ready = t.ordy; flush = t.fl;
    #1;
    accepted = rst_n && in_valid && in_ready;
    if (accepted) begin
      a = pick(t.fa, t.rs1, t.fwd);
      b = t.src ? t.imm : pick(t.fb, t.rs2, t.fwd);
      e.res   = ref_alu(t.op, a, b);
      e.bt    = W'(int'(t.pc) + int'(t.imm));
      e.rd    = t.rd;
      e.multi = (t.op >= 4'd8 && t.op <= 4'd10);
      e.acc   = cyc + 1;
      e.due   = e.multi ? cyc + 1 + W : cyc + 1;
      e.hold  = e.multi || !t.ordy;
      q.push_back(e);
    end
  endtask

  function automatic txn_t mk(input logic [3:0] op, input logic src, input logic [W-1:0] r1,
                              input logic [W-1:0] r2, input logic [W-1:0] im);
    txn_t t;
    t.iv = 1'b1; t.op = op; t.src = src; t.pc = 16'h0100; t.rs1 = r1; t.rs2 = r2;
    t.imm = im; t.rd = 4'd5; t.fa = '0; t.fb = '0; t.fwd = {16'hBEEF, 16'hCAFE};
    t.ordy = 1'b1; t.fl = 1'b0;
    return t;
  endfunction

  function automatic txn_t idle_t();
    txn_t t = mk(4'd0, 1'b0, '0, '0, '0);
    t.iv = 1'b0;
    return t;
  endfunction

  task automatic issue(input string nm, input txn_t t);
    bit acc = 0;
    for (int n = 0; n < 50 && !acc; n++) drive(t, acc);
    if (!acc) chk({nm, "_accept_timeout"}, 0, 1);
  endtask

  // Monitor: compares DUT against the scoreboard state every cycle
  initial begin
    bit          have_prev = 0;
    logic        prev_ov = 0, prev_rdy = 0, prev_fl = 0;
    logic [63:0] prev_data = '0;
    bit          ov_exp, busy_exp, hold_exp, ir_exp;
    exp_t        e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        chk("rst_out_valid", out_valid, 0);
        chk("rst_alu_result", alu_result, 0);
        chk("rst_branch_target", branch_target, 0);
        chk("rst_zero", zero, 0);
        chk("rst_rd_out", rd_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        q.delete();
        have_prev = 0;
      end else begin
        ov_exp   = (q.size() > 0) && (cyc >= q[0].due);
        busy_exp = (q.size() > 0) && q[0].multi && (cyc >= q[0].acc) && (cyc < q[0].due);
        hold_exp = ov_exp && q[0].hold;
        ir_exp   = !flush && !busy_exp && !hold_exp && (!ov_exp || out_ready);
        chk("out_valid", out_valid, ov_exp);
        chk("busy", busy, busy_exp);
        chk("in_ready", in_ready, ir_exp);
        if (have_prev && prev_ov && !prev_rdy && !prev_fl)
          chk("stable_outputs", {alu_result, branch_target, zero, rd_out}, prev_data);
        if (ov_exp && out_ready && !flush) begin
          e = q.pop_front();
          chk("alu_result", alu_result, e.res);
          chk("zero", zero, (e.res == '0));
          chk("branch_target", branch_target, e.bt);
          chk("rd_out", rd_out, e.rd);
        end
        if (flush) q.delete();
        have_prev = 1;
        prev_ov   = out_valid;
        prev_rdy  = out_ready;
        prev_fl   = flush;
        prev_data = 64'({alu_result, branch_target, zero, rd_out});
      end
    end
  end

  // Stimulus
  initial begin
    txn_t t;
    bit   acc;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive(idle_t(), acc);

    // Single-cycle boundary cases
    issue("add_ovf", mk(4'd0, 1'b1, 16'h7FFF, '0, 16'h0001));
    issue("sub_zero", mk(4'd1, 1'b0, 16'd5, 16'd5, '0));
    t = mk(4'd0, 1'b1, 16'hFFFF, '0, 16'h0001);
    t.fa = 2'd1; t.fwd = {16'h5555, 16'h1234};
    issue("fwd_a", t);
    t = mk(4'd0, 1'b0, 16'h0001, 16'h0002, '0);
    t.fb = 2'd3;
    issue("fwd_b_oor", t);
    t = mk(4'd1, 1'b0, 16'h0010, 16'h0000, '0);
    t.fb = 2'd2; t.fwd = {16'h0003, 16'h0000};
    issue("fwd_b_src1", t);

    // Iterative ops; repeated presentation shows in_ready held low
    issue("mul", mk(4'd8, 1'b0, 16'h0123, 16'h0010, '0));
    t = mk(4'd2, 1'b0, 16'hF0F0, 16'hFF00, '0);
    issue("and_after_mul", t);
    issue("divu", mk(4'd9, 1'b0, 16'd100, 16'd7, '0));
    issue("remu", mk(4'd10, 1'b0, 16'd100, 16'd7, '0));
    issue("divu0", mk(4'd9, 1'b0, 16'h00AB, 16'h0000, '0));
    issue("remu0", mk(4'd10, 1'b0, 16'h00AB, 16'h0000, '0));
    repeat (W + 2) drive(idle_t(), acc);

    // Back-pressure then simultaneous consume and accept
    issue("bp_first", mk(4'd4, 1'b0, 16'h00FF, 16'h0F0F, '0));
    t = mk(4'd3, 1'b0, 16'h1000, 16'h0001, '0);
    t.ordy = 1'b0;
    repeat (3) drive(t, acc);
    t.ordy = 1'b1;
    drive(t, acc);
    chk("consume_and_accept", acc, 1);
    repeat (2) drive(idle_t(), acc);

    // Flush during a divide
    issue("div_flush", mk(4'd9, 1'b0, 16'h1234, 16'h0007, '0));
    t = mk(4'd0, 1'b0, 16'd1, 16'd1, '0);
    repeat (5) drive(t, acc);
    t.fl = 1'b1;
    drive(t, acc);
    chk("flush_no_accept", acc, 0);
    repeat (2) drive(idle_t(), acc);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      t.iv   = ($urandom_range(0, 9) < 7);
      t.op   = 4'($urandom_range(0, 15));
      t.src  = 1'($urandom_range(0, 1));
      t.pc   = 16'($urandom);
      t.rs1  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 40)) : 16'($urandom);
      t.rs2  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 12)) : 16'($urandom);
      t.imm  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      t.rd   = 4'($urandom);
      t.fa   = 2'($urandom_range(0, 3));
      t.fb   = 2'($urandom_range(0, 3));
      t.fwd  = 32'($urandom);
      t.ordy = ($urandom_range(0, 3) != 0);
      t.fl   = ($urandom_range(0, 39) == 0);
      drive(t, acc);
    end
    repeat (W + 4) drive(idle_t(), acc);

    // Reset in the middle of a multiply
    issue("mul_rst", mk(4'd8, 1'b0, 16'h0F0F, 16'h0303, '0));
    repeat (6) drive(idle_t(), acc);
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue("post_rst_add", mk(4'd0, 1'b0, 16'h0002, 16'h0003, '0));
    repeat (W + 4) drive(idle_t(), acc);

    chk("drain_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
